// File: rtl/my_div3.sv
// rtl/my_div3.sv - fixed-latency unsigned restoring divider
// One quotient bit per RUN cycle; results and flags register on the DONE cycle.
module my_div3 #(
   parameter int DW = 45,
   parameter int VW = 21
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          busy,
   output logic          done,
   output logic          div_by_zero
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [DW-1:0] dvd_q;
   logic [VW-1:0] dsr_q;
   logic [VW:0]   rem_q;
   logic [CW-1:0] cnt_q;
   logic          zero_q;
   logic [VW:0]   rem_shift;
   logic [VW+1:0] trial;

   // Extra top bit of trial is the borrow: set means the subtraction went negative.
   always_comb begin
      rem_shift = {rem_q[VW-1:0], dvd_q[DW-1]};
      trial     = {1'b0, rem_shift} - {2'b00, dsr_q};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (divisor == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (cnt_q == '0) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Quotient bits shift into the dividend register as its bits are consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         dvd_q       <= '0;
         dsr_q       <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         zero_q      <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  dvd_q  <= dividend;
                  dsr_q  <= divisor;
                  rem_q  <= '0;
                  cnt_q  <= CW'(DW - 1);
                  zero_q <= (divisor == '0);
                  busy   <= 1'b1;
               end
            end
            RUN: begin
               rem_q <= trial[VW+1] ? rem_shift : trial[VW:0];
               dvd_q <= {dvd_q[DW-2:0], ~trial[VW+1]};
               cnt_q <= cnt_q - 1'b1;
            end
            DONE: begin
               done <= 1'b1;
               busy <= 1'b0;
               if (zero_q) begin
                  quotient    <= '1;
                  remainder   <= '0;
                  div_by_zero <= 1'b1;
               end else begin
                  quotient    <= dvd_q;
                  remainder   <= rem_q[VW-1:0];
                  div_by_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_my_div3.sv
// tb/tb_my_div3.sv - randomized and directed bench for my_div3
// Reference model counts down the fixed latency and divides with plain arithmetic.
module tb_my_div3;

   localparam int DW = 45;
   localparam int VW = 21;
   localparam logic [DW-1:0] DMAX = '1;
   localparam logic [VW-1:0] VMAX = '1;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          busy;
   logic          done;
   logic          div_by_zero;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   logic          m_busy;
   logic          m_done;
   logic          m_dz;
   logic [DW-1:0] m_q;
   logic [VW-1:0] m_r;
   logic [DW-1:0] m_a;
   logic [VW-1:0] m_b;
   int            m_cnt;

   my_div3 #(.DW(DW), .VW(VW)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .dividend(dividend),
      .divisor(divisor),
      .quotient(quotient),
      .remainder(remainder),
      .busy(busy),
      .done(done),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a division is a countdown of DW+1 edges (1 for a zero divisor).
   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_dz   <= 1'b0;
         m_q    <= '0;
         m_r    <= '0;
         m_cnt  <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               if (m_b == '0) begin
                  m_q  <= DMAX;
                  m_r  <= '0;
                  m_dz <= 1'b1;
               end else begin
                  m_q  <= DW'(longint'(m_a) / longint'(m_b));
                  m_r  <= VW'(longint'(m_a) % longint'(m_b));
                  m_dz <= 1'b0;
               end
            end
         end else if (start) begin
            m_a    <= dividend;
            m_b    <= divisor;
            m_busy <= 1'b1;
            m_cnt  <= (divisor == '0) ? 1 : DW + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("quotient", quotient, m_q);
         chk("remainder", remainder, m_r);
         chk("div_by_zero", div_by_zero, m_dz);
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_timeout", busy, 0);
   endtask

   task automatic run_op(input string nm, input logic [DW-1:0] a, input logic [VW-1:0] b,
                         input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic ez,
                         input int elat);
      int lat;
      int bcnt;
      wait_idle();
      start = 1'b1;
      dividend = a;
      divisor = b;
      @(posedge clk); #1;
      start = 1'b0;
      dividend = DW'({$urandom, $urandom});
      divisor = VW'($urandom);
      lat = 0;
      bcnt = busy ? 1 : 0;
      while (!done && lat < 200) begin
         @(posedge clk); #1;
         lat++;
         if (busy) bcnt++;
      end
      chk({nm, "_done"}, done, 1);
      chk({nm, "_latency"}, lat, elat);
      chk({nm, "_busy_cycles"}, bcnt, elat);
      chk({nm, "_q"}, quotient, eq);
      chk({nm, "_r"}, remainder, er);
      chk({nm, "_dz"}, div_by_zero, ez);
   endtask

   initial begin
      int nd;
      int n;
      int sel;
      rst = 1'b1;
      start = 1'b0;
      dividend = '0;
      divisor = '0;
      @(posedge clk); #1;
      cmp_en = 1'b1;
      start = 1'b1;
      dividend = 100;
      divisor = 7;
      @(posedge clk); #1;
      chk("reset_busy", busy, 0);
      chk("reset_q", quotient, 0);
      chk("reset_r", remainder, 0);
      chk("reset_done", done, 0);
      start = 1'b0;
      rst = 1'b0;

      run_op("d100_7", 100, 7, 14, 2, 0, 46);
      run_op("max_1", DMAX, 1, DMAX, 0, 0, 46);
      run_op("max_vmax", DMAX, VMAX, 16777224, 7, 0, 46);
      run_op("d5_9", 5, 9, 0, 5, 0, 46);
      run_op("d1234_0", 1234, 0, DMAX, 0, 1, 1);
      run_op("d10_3", 10, 3, 3, 1, 0, 46);

      // start held high with operands changed mid-run
      wait_idle();
      start = 1'b1;
      dividend = 20;
      divisor = 6;
      repeat (10) begin
         @(posedge clk); #1;
      end
      dividend = 999;
      divisor = 1;
      n = 0;
      while (!done && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("held_done", done, 1);
      chk("held_q", quotient, 3);
      chk("held_r", remainder, 2);
      @(posedge clk); #1;
      chk("held_reaccept_busy", busy, 1);
      chk("held_no_second_done", done, 0);
      start = 1'b0;
      n = 0;
      while (!done && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("held2_q", quotient, 999);
      chk("held2_r", remainder, 0);

      // reset during RUN aborts with no done pulse
      wait_idle();
      start = 1'b1;
      dividend = 100;
      divisor = 7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_q", quotient, 0);
      chk("abort_r", remainder, 0);
      chk("abort_dz", div_by_zero, 0);
      nd = 0;
      repeat (60) begin
         if (done) nd++;
         @(posedge clk); #1;
      end
      chk("abort_no_done", nd, 0);
      run_op("after_rst", 100, 7, 14, 2, 0, 46);

      // randomized traffic; the model checks every cycle
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         rst = ($urandom_range(599, 0) == 0);
         start = ($urandom_range(2, 0) == 0);
         sel = $urandom_range(7, 0);
         divisor = (sel == 0) ? '0 : (sel == 1) ? VW'($urandom_range(15, 1)) : VW'($urandom);
         dividend = ($urandom_range(3, 0) == 0) ? DW'($urandom_range(100, 0))
                                                : DW'({$urandom, $urandom});
      end
      rst = 1'b0;
      start = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
